icache_ctrl: RTL
================

# icache_ctrl

L1 instruction-cache controller that sequences the two-way L1 tag RAM (`tag_ram`) and data RAM (`data_ram`) for the IF stage. On every fetch it compares both ways, returns the addressed 32-bit word on a hit, and stalls the pipeline on a miss. During the stall it fetches the 128-bit line from L2 over a req/rdy handshake and writes the victim way's tag and data. It then replays the lookup. It sits between the IF stage, the L1 RAM pair and the L2 cache interface.

## Interface
Parameters: none. Widths are fixed by the RAMs: 8-bit index, 20-bit tag, 128-bit line.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address. Tag = [31:12], index = [11:4], word = [3:2].
- `insn` out 32: fetched word. Valid while `hit`=1.
- `hit` out 1: fetch completed this cycle.
- `miss_stall` out 1: pipeline stall.
- `index` out 8: RAM index to both RAMs.
- `tag0_rw`, `tag1_rw` out 1 each: tag-way write strobes (`WRITE`/`READ`).
- `tag_wd` out 20: tag write data.
- `tag0_rd`, `tag1_rd` in 21 each: {valid, tag}.
- `lru` in 1: LRU bit from `tag_ram`.
- `complete` in 1: tag write done, from `tag_ram`.
- `data0_rw`, `data1_rw` out 1 each: data-way write strobes.
- `data_wd` out 128: line write data.
- `data0_rd`, `data1_rd` in 128 each: line read data.
- `l2_req` out 1: L2 line request.
- `l2_addr` out 28: line address, = latched address [31:4].
- `l2_rdy` in 1: L2 data valid, one-cycle pulse.
- `l2_rdata` in 128: L2 line.

Reset values: `insn`=0, `hit`=0, `miss_stall`=0, all `*_rw`=`READ`, `tag_wd`=0, `data_wd`=0, `l2_req`=0, `l2_addr`=0, `index`=0. FSM resets to IDLE.

## Operation
FSM states: IDLE, L2_REQ, WRITE, WAIT.

**IDLE**
- `index` = `if_addr[11:4]`, driven combinationally. RAM reads are asynchronous, so the compare happens in the same cycle.
- Hit way *n*: `tagn_rd[20]`=1 and `tagn_rd[19:0]`=`if_addr[31:12]`.
  - `hit`=1 and `insn` = selected line word `if_addr[3:2]` (word 0 = bits [31:0]).
  - Stay in IDLE.
  - Both ways matching is an error; way 0 wins.
- Miss with `if_req`=1:
  - `miss_stall`=1 in the same cycle.
  - Latch `if_addr` into `addr_r`.
  - Choose victim: way 0 if it is invalid; else way 1 if it is invalid; else way 1 if `lru`=1, way 0 if `lru`=0. Latch the result into `way_r`.
  - Go to L2_REQ.
- `if_req`=0: `hit`=0, `miss_stall`=0.

**L2_REQ**
- `l2_req`=1 and `l2_addr` = `addr_r[31:4]`, both held stable.
- When `l2_rdy`=1: latch `l2_rdata` into `line_r` and go to WRITE.
- `l2_rdy` is ignored in every other state.

**WRITE** (exactly one cycle)
- `index` = `addr_r[11:4]`, `tag_wd` = `addr_r[31:12]`, `data_wd` = `line_r`.
- Assert `tag{way_r}_rw` and `data{way_r}_rw` = `WRITE`. The other way's strobes stay `READ`.
- Go to WAIT.

**WAIT**
- Strobes are back to `READ`, `index` = `addr_r[11:4]`.
- On `complete`=1, go to IDLE.

**Common rules**
- `miss_stall`=1 in L2_REQ, WRITE and WAIT.
- On return to IDLE the lookup replays against the current `if_addr`. IF holds its address while stalled, so this hits.
- `if_req` dropping mid-refill does not abort the refill. The line is still installed, then the FSM goes to IDLE.
- Hits do not update LRU; the RAM only updates LRU on writes.
- Synchronous reset (`reset`=0) in any state: next cycle IDLE, `l2_req`=0, strobes `READ`. A pending L2 response is dropped.

## Timing
- Hit: 0 cycles. `hit` and `insn` are combinational in the request cycle.
- Miss, relative to cycle M where the miss is detected:
  - M+1 onward: `l2_req`=1.
  - Cycle R: `l2_rdy` arrives.
  - R+1: write strobes asserted.
  - R+2: `complete`=1, FSM goes to IDLE.
  - R+3: replay hit, `hit`=1, `miss_stall`=0.
- Minimum miss penalty (L2 responds at M+1): 4 cycles.
- A miss detected in the same cycle reset deasserts is handled normally.

## Structure
- `icache.h`: state encodings (2 bits: IDLE=0, L2_REQ=1, WRITE=2, WAIT=3) and field constants for tag, index and word positions.
- `stddef.h`: `WRITE`/`READ` and `ENABLE`/`DISABLE`.
- One combinational sub-module, `icache_way_sel`: inputs are both tag words, `lru` and the address tag; outputs are `hit0`, `hit1` and `victim`. Shared with a future dcache controller.
- Registered state: FSM state, `addr_r`, `way_r`, `line_r`.

## Test plan
1. Reset, then fetch 0x0000_1000 into empty RAM → miss: `miss_stall`=1 that cycle and `l2_addr`=0x000_0100. L2 returns a line with word0=0xDEAD_BEEF after 5 cycles → `tag0_rw`=`WRITE` for one cycle, then `hit`=1 with `insn`=0xDEAD_BEEF.
2. Fetch 0x0000_100C after scenario 1 → `hit`=1 in the same cycle, `insn` = line bits [127:96], no L2 traffic.
3. Fetch 0x0000_2000 (same index, different tag) → victim way 1, `tag1_rw` pulses. Then fetch 0x0000_3000 with `lru`=1 → way 1 is replaced again.
4. `l2_rdy` pulse while in IDLE → ignored: no strobes, state unchanged.
5. `reset`=0 during L2_REQ → next cycle `l2_req`=0 and `miss_stall`=0. An `l2_rdy` arriving later writes nothing.
6. Drop `if_req` during L2_REQ → line still written and FSM returns to IDLE with `hit`=0. Re-issuing the same address then hits immediately.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl_pkg: shared encodings and field positions for the L1 icache controller
package icache_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_L2_REQ = 2'd1,
        ST_WRITE  = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;
    localparam logic WRITE   = 1'b1;
    localparam logic READ    = 1'b0;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int TAG_MSB  = 31;
    localparam int TAG_LSB  = 12;
    localparam int IDX_MSB  = 11;
    localparam int IDX_LSB  = 4;
    localparam int WORD_MSB = 3;
    localparam int WORD_LSB = 2;
    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] w);
        return line[w*32 +: 32];
    endfunction
endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: IF-stage, L1 tag/data RAM and L2 signals of the icache controller
interface icache_ctrl_if;
    logic         if_req;
    logic [31:0]  if_addr;
    logic [31:0]  insn;
    logic         hit;
    logic         miss_stall;
    logic [7:0]   index;
    logic         tag0_rw;
    logic         tag1_rw;
    logic [19:0]  tag_wd;
    logic [20:0]  tag0_rd;
    logic [20:0]  tag1_rd;
    logic         lru;
    logic         complete;
    logic         data0_rw;
    logic         data1_rw;
    logic [127:0] data_wd;
    logic [127:0] data0_rd;
    logic [127:0] data1_rd;
    logic         l2_req;
    logic [27:0]  l2_addr;
    logic         l2_rdy;
    logic [127:0] l2_rdata;
    modport master (
        input  if_req, if_addr, tag0_rd, tag1_rd, lru, complete, data0_rd, data1_rd, l2_rdy, l2_rdata,
        output insn, hit, miss_stall, index, tag0_rw, tag1_rw, tag_wd, data0_rw, data1_rw, data_wd,
               l2_req, l2_addr
    );
    modport slave (
        output if_req, if_addr, tag0_rd, tag1_rd, lru, complete, data0_rd, data1_rd, l2_rdy, l2_rdata,
        input  insn, hit, miss_stall, index, tag0_rw, tag1_rw, tag_wd, data0_rw, data1_rw, data_wd,
               l2_req, l2_addr
    );
endinterface

// File: rtl/icache_way_sel.sv
// icache_way_sel: two-way tag compare and victim choice (invalid way first, else LRU)
module icache_way_sel (
    input  logic [20:0] tag0_rd,
    input  logic [20:0] tag1_rd,
    input  logic        lru,
    input  logic [19:0] tag,
    output logic        hit0,
    output logic        hit1,
    output logic        victim
);
    assign hit0   = tag0_rd[20] && tag0_rd[19:0] == tag;
    assign hit1   = tag1_rd[20] && tag1_rd[19:0] == tag;
    assign victim = !tag0_rd[20] ? 1'b0 : !tag1_rd[20] ? 1'b1 : lru;
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: two-way L1 icache controller, same-cycle hit compare and L2 line refill on miss
module icache_ctrl
    import icache_ctrl_pkg::*;
(
    input logic           clk,
    input logic           reset,
    icache_ctrl_if.master bus
);
    state_t       state;
    logic [31:0]  addr_r;
    logic         way_r;
    logic [127:0] line_r;
    logic         l2_req_r;
    logic [1:0]   wr_r;
    logic         hit0;
    logic         hit1;
    logic         victim;
    logic         idle;
    logic         lookup;
    logic         any_hit;
    logic         req_miss;
    icache_way_sel u_way_sel (
        .tag0_rd (bus.tag0_rd),
        .tag1_rd (bus.tag1_rd),
        .lru     (bus.lru),
        .tag     (bus.if_addr[TAG_MSB:TAG_LSB]),
        .hit0    (hit0),
        .hit1    (hit1),
        .victim  (victim)
    );
    assign idle     = state == ST_IDLE;
    assign lookup   = reset && idle && bus.if_req;
    assign any_hit  = hit0 || hit1;
    assign req_miss = lookup && !any_hit;
    // way 0 wins if both ways report the same tag
    assign bus.hit        = lookup && any_hit;
    assign bus.insn       = (lookup && any_hit) ?
                            line_word(hit0 ? bus.data0_rd : bus.data1_rd, bus.if_addr[WORD_MSB:WORD_LSB]) : '0;
    assign bus.miss_stall = req_miss || (reset && !idle);
    assign bus.index      = !reset ? '0 : idle ? bus.if_addr[IDX_MSB:IDX_LSB] : addr_r[IDX_MSB:IDX_LSB];
    assign bus.tag_wd     = addr_r[TAG_MSB:TAG_LSB];
    assign bus.data_wd    = line_r;
    assign bus.l2_addr    = addr_r[31:4];
    assign bus.l2_req     = l2_req_r;
    assign bus.tag0_rw    = wr_r[0];
    assign bus.tag1_rw    = wr_r[1];
    assign bus.data0_rw   = wr_r[0];
    assign bus.data1_rw   = wr_r[1];
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            addr_r   <= '0;
            way_r    <= 1'b0;
            line_r   <= '0;
            l2_req_r <= DISABLE;
            wr_r     <= {READ, READ};
        end else begin
            wr_r <= {READ, READ};
            case (state)
                ST_IDLE: if (req_miss) begin
                    addr_r   <= bus.if_addr;
                    way_r    <= victim;
                    l2_req_r <= ENABLE;
                    state    <= ST_L2_REQ;
                end
                ST_L2_REQ: if (bus.l2_rdy) begin
                    line_r   <= bus.l2_rdata;
                    l2_req_r <= DISABLE;
                    wr_r     <= {way_r ? WRITE : READ, way_r ? READ : WRITE};
                    state    <= ST_WRITE;
                end
                ST_WRITE: state <= ST_WAIT;
                ST_WAIT:  if (bus.complete) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule
